sync_multi_filt: RTL
====================

Name: sync_multi_filt

Overview:
- Parametrised successor to the single-bit two-flop synchroniser.
- Synchronises N_CH independent asynchronous level inputs into the clk domain through a configurable flop chain.
- Each channel then has a glitch/stability filter and registered rise/fall pulse detection.
- Used at every quasi-static control/status input crossing into a clock domain (straps, remote-domain flags, pins).

Parameters:
- N_CH, 4, number of independent channels (>=1).
- STAGES, 2, synchroniser flop depth per channel (>=2).
- FILTER_CYCLES, 3, consecutive cycles a new synchronised value must hold before q_out accepts it (>=1).
- RESET_VAL, '0 (N_CH bits), per-channel reset value of the sync chain and q_out.

Ports:
- clk  input  1  single clock; all flops on posedge.
- rst_n  input  1  asynchronous active-low reset.
- d_in  input  N_CH  asynchronous level inputs, no timing relation to clk.
- q_out  output  N_CH  filtered, synchronised levels.
- rise_pulse  output  N_CH  one-cycle high when q_out[i] goes 0->1.
- fall_pulse  output  N_CH  one-cycle high when q_out[i] goes 1->0.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low. While rst_n=0:
  - all sync flops[i] and q_out[i] = RESET_VAL[i];
  - filter counters = 0;
  - rise_pulse and fall_pulse = 0.
- Deassertion is sampled synchronously by the instantiating reset synchroniser (not in this block).
- Sync chain: per channel, s[0] <= d_in[i], s[k] <= s[k-1]. sync[i] = s[STAGES-1]. No logic between stages. The chain carries the team's ASYNC_REG/sync attribute.
- Filter, per channel: counter cnt, width $clog2(FILTER_CYCLES+1). Each posedge:
  - if sync==q_out: cnt<=0, no pulse.
  - else if cnt==FILTER_CYCLES-1: q_out<=sync, cnt<=0, rise_pulse<=sync, fall_pulse<=~sync.
  - else: cnt<=cnt+1, no pulse.
- Pulses are registered. Each is high for exactly one cycle, in the same cycle q_out first shows the new value. rise_pulse and fall_pulse are never both high on one channel.
- Latency: a d_in change that is stable before posedge 0 is visible on q_out after posedge STAGES+FILTER_CYCLES-1. With defaults, q_out changes at posedge 4.
- Glitch rejection: a sync value differing from q_out for fewer than FILTER_CYCLES consecutive cycles is dropped. cnt clears when sync returns to q_out, so there is no accumulation across glitches.
- FILTER_CYCLES=1: q_out follows sync with one register delay. Every change is accepted.
- Channels are fully independent. Simultaneous changes on several channels give simultaneous independent pulses.
- Reset mid-filter: cnt is discarded and q_out returns to RESET_VAL with no pulse. After release, a d_in differing from RESET_VAL is filtered normally and produces a pulse.
- Multi-bit d_in is NOT coherent across channels; buses need a handshake or gray code upstream.

Optional Feature:
- Macro SYNC_RANDOM_DELAY_EN.
- Defined, and SYNTH not defined: each channel adds 0..2 extra sync stages. The count is chosen per channel at elaboration via $urandom, to model metastability-resolution uncertainty in simulation.
- Not defined, or SYNTH defined: exactly STAGES stages per channel, fully deterministic.
- Filter and pulse behaviour are identical in both cases; only sync latency varies.

Test Plan:
- Reset: rst_n=0 with RESET_VAL=4'b0101, d_in toggling -> q_out=4'b0101, pulses 0, throughout reset.
- Latency: defaults, rst_n=1, d_in[0] 0->1 before posedge 0 and held -> q_out[0]=1 and rise_pulse[0]=1 at posedge 4 only; rise_pulse[0]=0 at posedge 5.
- Glitch: d_in[1] high for 2 clk cycles, then low (FILTER_CYCLES=3) -> q_out[1] stays 0, no pulses. A 3-cycle pulse -> q_out[1] rises, rise_pulse[1] for 1 cycle, then falls after FILTER_CYCLES with fall_pulse[1].
- Multi-channel: d_in 4'b0000->4'b1111 on one cycle -> rise_pulse=4'b1111 for exactly one cycle; then 4'b1010 -> fall_pulse=4'b0101 for one cycle.
- Reset mid-filter: d_in[2] rises, rst_n=0 asynchronously two cycles later -> q_out[2] stays 0, no pulse. Release with d_in[2]=1 held -> q_out[2]=1 after STAGES+FILTER_CYCLES cycles, with one rise_pulse.
- FILTER_CYCLES=1, STAGES=3: d_in[3] alternating every 4 cycles -> q_out[3] mirrors it with 3-cycle latency, one pulse per edge.

Source files
------------

// File: rtl/sync_multi_filt.sv
// N_CH-channel level synchroniser with a per-channel stability filter and registered rise/fall pulses.
// Optional macro SYNC_RANDOM_DELAY_EN (ignored when SYNTH is defined) adds 0..2 random extra sync stages per channel.
module sync_multi_filt #(
  parameter int              N_CH          = 4,
  parameter int              STAGES        = 2,
  parameter int              FILTER_CYCLES = 3,
  parameter logic [N_CH-1:0] RESET_VAL     = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] d_in,
  output logic [N_CH-1:0] q_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
);

`ifdef SYNC_RANDOM_DELAY_EN
`ifdef SYNTH
  localparam int EXTRA_MAX = 0;
`else
  localparam int EXTRA_MAX = 2;
`endif
`else
  localparam int EXTRA_MAX = 0;
`endif

  localparam int                 DEPTH    = STAGES + EXTRA_MAX;
  localparam int                 CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] sync_q [N_CH];
  logic [DEPTH-1:0] sync_d [N_CH];
  logic [N_CH-1:0]  sync_w;

  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [N_CH-1:0]  q_q, q_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;

  // Pure shift chain: nothing may sit between synchroniser stages.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sync_d[i] = {sync_q[i][DEPTH-2:0], d_in[i]};
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_tap
`ifdef SYNC_RANDOM_DELAY_EN
`ifndef SYNTH
    int unsigned extra = $urandom_range(EXTRA_MAX, 0);
    assign sync_w[i] = sync_q[i][STAGES - 1 + int'(extra)];
`else
    assign sync_w[i] = sync_q[i][STAGES-1];
`endif
`else
    assign sync_w[i] = sync_q[i][STAGES-1];
`endif
  end

  // Filter: a differing value must persist FILTER_CYCLES consecutive cycles; any return clears the count.
  always_comb begin
    q_d    = q_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_w[i] == q_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        q_d[i]    = sync_w[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync_w[i];
        fall_d[i] = ~sync_w[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= {DEPTH{RESET_VAL[i]}};
        cnt_q[i]  <= '0;
      end
      q_q    <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_out      = q_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule
